// File: rtl/savestate_pkg.sv
// rtl/savestate_pkg.sv - shared save-state chunk descriptor fields, markers and endpoint states
package savestate_pkg;

    typedef enum logic [1:0] {
        WC_8  = 2'd0,
        WC_16 = 2'd1,
        WC_32 = 2'd2,
        WC_64 = 2'd3
    } width_code_t;

    localparam int DESC_LEN_LSB   = 0;
    localparam int DESC_LEN_MSB   = 31;
    localparam int DESC_WIDTH_LSB = 32;
    localparam int DESC_WIDTH_MSB = 33;
    localparam int DESC_INDEX_LSB = 56;
    localparam int DESC_INDEX_MSB = 63;

    localparam logic [63:0] DESC_END = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DROP
    } state_t;

    function automatic logic [63:0] make_desc(input width_code_t wc, input logic [31:0] len);
        logic [63:0] d;
        d = '0;
        d[DESC_LEN_MSB:DESC_LEN_LSB]     = len;
        d[DESC_WIDTH_MSB:DESC_WIDTH_LSB] = wc;
        return d;
    endfunction

endpackage

// File: rtl/dualport_ram.sv
// rtl/dualport_ram.sv - true dual-port RAM, registered reads, port B write wins on collision
module dualport_ram #(
    parameter int W  = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [W-1:0]  a_wdata,
    output logic [W-1:0]  a_rdata,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [W-1:0]  b_wdata,
    output logic [W-1:0]  b_rdata
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] a_rdata_q;
    logic [W-1:0] b_rdata_q;

    // Reads sample the array before this edge's writes land, so read-during-write returns old data.
    always_ff @(posedge clk) begin
        a_rdata_q <= mem[a_addr];
        b_rdata_q <= mem[b_addr];
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/savestate_chunk_ram.sv
// rtl/savestate_chunk_ram.sv - memory_stream endpoint exposing a core RAM as one save-state chunk
module savestate_chunk_ram
    import savestate_pkg::*;
#(
    parameter  int WIDTH_CODE = 0,
    parameter  int DEPTH      = 1024,
    parameter  int AW         = $clog2(DEPTH),
    localparam int W          = 8 << WIDTH_CODE
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          chunk_select,
    input  logic          query_req,
    input  logic          read_req,
    input  logic          write_req,
    input  logic [31:0]   chunk_address,
    input  logic [63:0]   write_data,
    output logic          data_ack,
    output logic [63:0]   read_data,
    input  logic [AW-1:0] core_addr,
    input  logic          core_we,
    input  logic [W-1:0]  core_wdata,
    output logic [W-1:0]  core_rdata,
    output logic          mismatch,
    input  logic          mismatch_clr
);

    localparam logic [63:0] DESC = make_desc(width_code_t'(WIDTH_CODE), 32'(DEPTH));

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [63:0] rdata_q, rdata_d;
    logic        mismatch_q, mismatch_d;
    logic        armed_q, armed_d;
    logic        oor_q, oor_d;

    logic         req, go, in_range, desc_match, b_we;
    logic [W-1:0] b_rdata;
    logic         unused_write_bits;

    assign req        = read_req | write_req;
    assign go         = chunk_select & req & armed_q;
    assign in_range   = chunk_address < 32'(DEPTH);
    assign desc_match = write_data[33:0] == DESC[33:0];
    assign b_we       = (state_q == ST_IDLE) & go & ~query_req & write_req & ~read_req & in_range;
    assign unused_write_bits = ^write_data[63:34];

    dualport_ram #(.W(W), .AW(AW)) u_ram (
        .clk     (clk),
        .a_we    (core_we),
        .a_addr  (core_addr),
        .a_wdata (core_wdata),
        .a_rdata (core_rdata),
        .b_we    (b_we),
        .b_addr  (chunk_address[AW-1:0]),
        .b_wdata (write_data[W-1:0]),
        .b_rdata (b_rdata)
    );

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        mismatch_d = mismatch_q;
        armed_d    = armed_q;
        oor_d      = oor_q;
        if (mismatch_clr) mismatch_d = 1'b0;
        case (state_q)
            ST_IDLE: if (go) begin
                state_d = ST_DROP;
                if (query_req && read_req) begin
                    rdata_d = DESC;
                    ack_d   = 1'b1;
                end else if (query_req) begin
                    if (desc_match) ack_d = 1'b1;
                    else            mismatch_d = 1'b1;
                end else if (read_req) begin
                    oor_d   = ~in_range;
                    state_d = ST_FETCH;
                end else begin
                    ack_d = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!chunk_select) begin
                    state_d = ST_IDLE;
                end else begin
                    rdata_d = oor_q ? 64'd0 : 64'(b_rdata);
                    ack_d   = 1'b1;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: if (!req || !chunk_select) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A held request must not be served twice: rearm only once the stream lets go.
        if (!req)  armed_d = 1'b1;
        if (ack_d) armed_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            mismatch_q <= 1'b0;
            armed_q    <= 1'b1;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            mismatch_q <= mismatch_d;
            armed_q    <= armed_d;
            oor_q      <= oor_d;
        end
    end

    assign data_ack  = ack_q;
    assign read_data = rdata_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_savestate_chunk_ram.sv
// tb/tb_savestate_chunk_ram.sv - self-checking bench for savestate_chunk_ram
module tb_savestate_chunk_ram;

    localparam int WC    = 1;
    localparam int DEPTH = 1024;
    localparam int W     = 16;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          chunk_select = 1'b0;
    logic          query_req = 1'b0;
    logic          read_req = 1'b0;
    logic          write_req = 1'b0;
    logic [31:0]   chunk_address = '0;
    logic [63:0]   write_data = '0;
    logic          data_ack;
    logic [63:0]   read_data;
    logic [AW-1:0] core_addr = '0;
    logic          core_we = 1'b0;
    logic [W-1:0]  core_wdata = '0;
    logic [W-1:0]  core_rdata;
    logic          mismatch;
    logic          mismatch_clr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string       name;
        bit          q, r, w;
        logic [31:0] addr;
        logic [63:0] wdata;
        bit          exp_ack;
        int          exp_lat;
        bit          chk_data;
        logic [63:0] exp_data;
        bit          hold;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    savestate_chunk_ram #(.WIDTH_CODE(WC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .chunk_select  (chunk_select),
        .query_req     (query_req),
        .read_req      (read_req),
        .write_req     (write_req),
        .chunk_address (chunk_address),
        .write_data    (write_data),
        .data_ack      (data_ack),
        .read_data     (read_data),
        .core_addr     (core_addr),
        .core_we       (core_we),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .mismatch      (mismatch),
        .mismatch_clr  (mismatch_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drop_req();
        query_req = 1'b0;
        read_req  = 1'b0;
        write_req = 1'b0;
    endtask

    task automatic stream_req(input vec_t v);
        vec_t        e;
        bit          got;
        int          lat;
        logic [63:0] data;
        sb.push_back(v);
        @(posedge clk); #1;
        chunk_select  = 1'b1;
        query_req     = v.q;
        read_req      = v.r;
        write_req     = v.w;
        chunk_address = v.addr;
        write_data    = v.wdata;
        got  = 1'b0;
        lat  = 0;
        data = '0;
        for (int i = 1; i <= 16 && !got; i++) begin
            @(posedge clk); #1;
            if (data_ack) begin
                got  = 1'b1;
                lat  = i;
                data = read_data;
            end
        end
        e = sb.pop_front();
        if (got && e.hold) begin
            @(posedge clk); #1;
            check({e.name, "_single_pulse"}, 64'(data_ack), 64'd0);
        end
        drop_req();
        check({e.name, "_ack"}, 64'(got), 64'(e.exp_ack));
        if (got && e.exp_ack) check({e.name, "_lat"}, 64'(lat), 64'(e.exp_lat));
        if (got && e.chk_data) check({e.name, "_data"}, data, e.exp_data);
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(posedge clk); #1;
        core_we = 1'b1; core_addr = a; core_wdata = d;
        @(posedge clk); #1;
        core_we = 1'b0;
    endtask

    task automatic core_read(input logic [AW-1:0] a, output logic [W-1:0] d);
        @(posedge clk); #1;
        core_addr = a;
        @(posedge clk); #1;
        d = core_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rd;
        int           acks;
        vec_t         v;

        vecs[0]  = '{"gather",       1, 1, 0, 32'd0,    64'h0,           1, 1, 1, 64'h0000_0001_0000_0400, 1};
        vecs[1]  = '{"scatter_ok",   1, 0, 1, 32'd0,    64'h1_0000_0400, 1, 1, 0, 64'h0, 0};
        vecs[2]  = '{"scatter_bad",  1, 0, 1, 32'd0,    64'h1_0000_0200, 0, 0, 0, 64'h0, 0};
        vecs[3]  = '{"wr3",          0, 0, 1, 32'd3,    64'hFFFF_1234,   1, 1, 0, 64'h0, 1};
        vecs[4]  = '{"wr1027_oor",   0, 0, 1, 32'd1027, 64'h5555,        1, 1, 0, 64'h0, 0};
        vecs[5]  = '{"rd3",          0, 1, 0, 32'd3,    64'h0,           1, 2, 1, 64'h1234, 0};
        vecs[6]  = '{"rd1027_oor",   0, 1, 0, 32'd1027, 64'h0,           1, 2, 1, 64'h0, 0};
        vecs[7]  = '{"rd1024_oor",   0, 1, 0, 32'd1024, 64'h0,           1, 2, 1, 64'h0, 0};
        vecs[8]  = '{"rdwr_as_rd",   0, 1, 1, 32'd3,    64'h9999,        1, 2, 1, 64'h1234, 0};
        vecs[9]  = '{"rd3_again",    0, 1, 0, 32'd3,    64'h0,           1, 2, 1, 64'h1234, 0};
        vecs[10] = '{"wr1023",       0, 0, 1, 32'd1023, 64'hABCD,        1, 1, 0, 64'h0, 0};
        vecs[11] = '{"rd1023",       0, 1, 0, 32'd1023, 64'h0,           1, 2, 1, 64'hABCD, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 64'(data_ack), 64'd0);
        check("reset_rdata", read_data, 64'd0);
        check("reset_mismatch", 64'(mismatch), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) stream_req(vecs[i]);

        check("mismatch_sticky", 64'(mismatch), 64'd1);
        @(posedge clk); #1; mismatch_clr = 1'b1;
        @(posedge clk); #1; mismatch_clr = 1'b0;
        check("mismatch_clr", 64'(mismatch), 64'd0);

        // Clear and a fresh mismatch in the same cycle: the set must win.
        mismatch_clr = 1'b1; chunk_select = 1'b1; query_req = 1'b1; write_req = 1'b1;
        write_data = 64'h1_0000_0200;
        @(posedge clk); #1;
        mismatch_clr = 1'b0; drop_req();
        check("mismatch_set_wins", 64'(mismatch), 64'd1);
        @(posedge clk); #1; mismatch_clr = 1'b1;
        @(posedge clk); #1; mismatch_clr = 1'b0;
        check("mismatch_clr2", 64'(mismatch), 64'd0);

        core_read(10'd3, rd);
        check("core_rd3", 64'(rd), 64'h1234);
        core_read(10'd1023, rd);
        check("core_rd1023", 64'(rd), 64'hABCD);

        core_write(10'd5, 16'hBEEF);
        v = '{"save5", 0, 1, 0, 32'd5, 64'h0, 1, 2, 1, 64'hBEEF, 1};
        stream_req(v);

        // Select drops while the fetch is in flight: no acknowledge may appear.
        @(posedge clk); #1;
        chunk_select = 1'b1; read_req = 1'b1; chunk_address = 32'd5;
        @(posedge clk); #1;
        chunk_select = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (data_ack) acks++;
        end
        check("select_drop_no_ack", 64'(acks), 64'd0);
        drop_req();
        chunk_select = 1'b1;

        // Reset lands while the endpoint sits in DROP after an acknowledged write.
        @(posedge clk); #1;
        write_req = 1'b1; chunk_address = 32'd9; write_data = 64'h42;
        @(posedge clk); #1;
        check("pre_reset_ack", 64'(data_ack), 64'd1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_ack", 64'(data_ack), 64'd0);
        check("reset_mid_rdata", read_data, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drop_req();
        v = '{"after_reset", 0, 1, 0, 32'd5, 64'h0, 1, 2, 1, 64'hBEEF, 0};
        stream_req(v);

        for (int i = 0; i < 16; i++) core_write(AW'(i), W'(i * 37 + 100));
        for (int i = 0; i < 16; i++) begin
            v = '{$sformatf("b2b%0d", i), 0, 1, 0, 32'(i), 64'h0, 1, 2, 1, 64'(W'(i * 37 + 100)), 0};
            stream_req(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
